// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame states and scan-code constants for the PS/2 receiver.
// Revision: 1.0
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_PAUSE  = 8'hE1;

    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ERR0   = 8'h00;
    localparam logic [7:0] CODE_ERR1   = 8'hFF;

    // Bytes that follow E1 in a Pause make/break sequence and must be swallowed.
    localparam logic [2:0] PAUSE_SKIP  = 3'd7;

    function automatic logic is_protocol_code(input logic [7:0] code);
        return (code == CODE_BAT_OK) || (code == CODE_ACK)  || (code == CODE_ECHO) ||
               (code == CODE_RESEND) || (code == CODE_ERR0) || (code == CODE_ERR1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus counter debounce with a registered falling-edge pulse.
// Revision: 1.0
`default_nettype none

module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic line_fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1;
    logic             sync2;
    logic             filt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            filt      <= 1'b1;
            cnt       <= '0;
            line_fall <= 1'b0;
        end else begin
            sync1     <= line_in;
            sync2     <= sync1;
            line_fall <= 1'b0;
            // Any sample agreeing with the current level restarts the run count.
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                filt      <= sync2;
                cnt       <= '0;
                line_fall <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 set-2 frame receiver and E0/F0/E1 prefix folder producing key events.
// Revision: 1.0. Optional frame watchdog enabled by defining PS2RX_TIMEOUT_EN.
`default_nettype none

module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    logic         clk_fall;
    logic         dat_meta;
    logic         dat_sync;
    frame_state_t state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         par_bit;
    logic         byte_valid;
    logic         timeout_hit;
    logic         ext;
    logic         rel;
    logic [2:0]   skip_cnt;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .line_in   (ps2_clk),
        .line_fall (clk_fall)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

`ifdef PS2RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (clk_fall || (state == ST_IDLE)) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A falling edge arriving together with expiry keeps the frame alive.
    assign timeout_hit = (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES)) && !clk_fall;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (clk_fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg <= {dat_sync, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= dat_sync;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (dat_sync && (^{shreg, par_bit})) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // shreg stays stable in the byte_valid cycle: no new start bit can land that soon.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext          <= 1'b0;
            rel          <= 1'b0;
            skip_cnt     <= 3'd0;
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
        end else begin
            key_strobe <= 1'b0;
            if (frame_err) begin
                ext      <= 1'b0;
                rel      <= 1'b0;
                skip_cnt <= 3'd0;
            end else if (byte_valid) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (shreg == CODE_PAUSE) begin
                    skip_cnt <= PAUSE_SKIP;
                end else if (shreg == CODE_EXT) begin
                    ext <= 1'b1;
                end else if (shreg == CODE_BREAK) begin
                    rel <= 1'b1;
                end else if (!(is_protocol_code(shreg) && !ext && !rel)) begin
                    key_code     <= shreg;
                    key_extended <= ext;
                    key_pressed  <= ~rel;
                    key_strobe   <= 1'b1;
                    ext          <= 1'b0;
                    rel          <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: bit-banged PS/2 keyboard stimulus against a byte-level key-event model.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_scancode_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int HALF           = 15;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int strobe_cnt = 0, err_cnt = 0, hold_viol = 0, wide_strobe = 0;
    int last_strobe_cyc = 0, last_err_cyc = 0, stop_fall_cyc = 0;

    logic [9:0] obs_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] prev_out    = 10'd0;
    logic       prev_strobe = 1'b0;

    bit m_ext, m_rel;
    int m_skip;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (key_strobe) begin
                obs_q.push_back({key_code, key_pressed, key_extended});
                strobe_cnt++;
                last_strobe_cyc = cyc;
                if (prev_strobe) wide_strobe++;
            end else if ({key_code, key_pressed, key_extended} !== prev_out) begin
                hold_viol++;
            end
            if (frame_err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
        end
        prev_out    = {key_code, key_pressed, key_extended};
        prev_strobe = key_strobe;
    end

    // Key-event reference: one event per completed set-2 sequence.
    function automatic void model_byte(input logic [7:0] b);
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else if (!m_ext && !m_rel &&
                 (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF)) ;
        else begin
            exp_q.push_back({b, !m_rel, m_ext});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endfunction

    function automatic void model_clear();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        cycles(HALF);
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0);
        model_byte(b);
    endtask

    task automatic test_reset();
        cycles(5);
        checks += 5;
        if (key_strobe !== 1'b0)   begin failures++; $display("FAIL reset_strobe got=%b want=0", key_strobe); end
        if (key_pressed !== 1'b0)  begin failures++; $display("FAIL reset_pressed got=%b want=0", key_pressed); end
        if (key_extended !== 1'b0) begin failures++; $display("FAIL reset_ext got=%b want=0", key_extended); end
        if (key_code !== 8'h00)    begin failures++; $display("FAIL reset_code got=%h want=00", key_code); end
        if (frame_err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b want=0", frame_err); end
        reset_n = 1'b1;
        cycles(10);
        checks++;
        if (strobe_cnt !== 0 || err_cnt !== 0) begin
            failures++; $display("FAIL reset_quiet got strobes=%0d errs=%0d want 0/0", strobe_cnt, err_cnt);
        end
    endtask

    task automatic test_make();
        logic [9:0] got;
        int s0;
        s0 = strobe_cnt;
        send_byte(8'h1C);
        cycles(20);
        checks += 3;
        if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL make_count got=%0d want=1", strobe_cnt - s0); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL make_event got=%h want=%h", got, {8'h1C, 2'b10}); end
        if (last_strobe_cyc - stop_fall_cyc !== FILTER_LEN + 4) begin
            failures++; $display("FAIL make_latency got=%0d want=%0d", last_strobe_cyc - stop_fall_cyc, FILTER_LEN + 4);
        end
    endtask

    task automatic test_breaks();
        logic [9:0] got;
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        cycles(20);
        checks++;
        if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
            failures++; $display("FAIL break_count got=%0d want=2", obs_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
            checks++;
            if (got !== exp_q[0]) begin failures++; $display("FAIL break_event%0d got=%h want=%h", i, got, exp_q[0]); end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_parity_error();
        logic [9:0] got;
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_byte(8'hF0);
        send_frame(8'h1D, 1'b1);
        model_clear();
        cycles(20);
        checks += 3;
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err_count got=%0d want=1", err_cnt - e0); end
        if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL parity_no_strobe got=%0d want=0", strobe_cnt - s0); end
        if (last_err_cyc - stop_fall_cyc !== FILTER_LEN + 3) begin
            failures++; $display("FAIL parity_err_latency got=%0d want=%0d", last_err_cyc - stop_fall_cyc, FILTER_LEN + 3);
        end
        send_byte(8'h1D);
        cycles(20);
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        checks++;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL parity_recover got=%h want=%h", got, {8'h1D, 2'b10}); end
    endtask

    task automatic test_timeout();
        logic [9:0] got;
        int e0;
        send_byte(8'hE0);
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        cycles(TIMEOUT_CYCLES + 40);
        checks++;
`ifdef PS2RX_TIMEOUT_EN
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
        model_clear();
`else
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL timeout_none got=%0d want=0", err_cnt - e0); end
        reset_n = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        model_clear();
        cycles(5);
`endif
        send_byte(8'h16);
        cycles(20);
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        checks++;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL timeout_recover got=%h want=%h", got, {8'h16, 2'b10}); end
    endtask

    task automatic test_pause();
        logic [9:0] got;
        int s0;
        logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        s0 = strobe_cnt;
        foreach (seq[i]) send_byte(seq[i]);
        cycles(20);
        checks += 2;
        if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL pause_count got=%0d want=1", strobe_cnt - s0); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL pause_event got=%h want=%h", got, {8'h16, 2'b10}); end
    endtask

    task automatic test_glitch();
        logic [9:0] got;
        int e0;
        e0 = err_cnt;
        ps2_dat = 1'b0;
        cycles(2);
        ps2_clk = 1'b0;
        cycles(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        cycles(2);
        ps2_dat = 1'b1;
        cycles(20);
        send_byte(8'h1C);
        cycles(20);
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        checks += 2;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL glitch_event got=%h want=%h", got, {8'h1C, 2'b10}); end
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] got;
        send_byte(8'hE0);
        for (int i = 0; i < 5; i++) send_bit(1'b1 ^ i[0]);
        ps2_dat = 1'b1;
        reset_n = 1'b0;
        cycles(3);
        checks++;
        if ({key_strobe, key_pressed, key_extended, key_code, frame_err} !== 12'd0) begin
            failures++; $display("FAIL midreset_outputs got=%h want=000", {key_strobe, key_pressed, key_extended, key_code, frame_err});
        end
        reset_n = 1'b1;
        model_clear();
        cycles(10);
        send_byte(8'h5A);
        cycles(20);
        got = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
        checks++;
        if (got !== exp_q.pop_front()) begin failures++; $display("FAIL midreset_event got=%h want=%h", got, {8'h5A, 2'b10}); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        logic [7:0] stray [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        obs_q.delete();
        exp_q.delete();
        for (int n = 0; n < 25; n++) begin
            logic [7:0] code;
            bit ext, rel;
            ext  = 1'($urandom_range(0, 1));
            rel  = 1'($urandom_range(0, 1));
            code = 8'($urandom_range(1, 127));
            if (ext && $urandom_range(0, 3) == 0) code = stray[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) send_byte(stray[$urandom_range(0, 5)]);
            if (ext) send_byte(8'hE0);
            if (rel) send_byte(8'hF0);
            send_byte(code);
        end
        cycles(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            checks++;
            if (got !== exp_q[0]) begin failures++; $display("FAIL random_event got=%h want=%h", got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        checks += 2;
        if (hold_viol !== 0) begin failures++; $display("FAIL output_hold got=%0d want=0", hold_viol); end
        if (wide_strobe !== 0) begin failures++; $display("FAIL strobe_width got=%0d want=0", wide_strobe); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_make();
        test_breaks();
        test_parity_error();
        test_timeout();
        test_pause();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
